mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS datapath. It sequences one instruction over 2–5 cycles through the shared ALU, memory and register-file write port. Each cycle it drives the datapath select lines: regdst, alusrc, memtoreg, next-PC select and ALU op. It also drives the PC/IR/regfile/memory write enables, and it handshakes with a memory that may stall.

---
 rtl/mips_defs.sv | 59 +++++
 rtl/mc_ctrl_if.sv | 37 +++
 rtl/mc_decode.sv | 32 +++
 rtl/mc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path and the
// datapath select muxes it steers.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_RS  = 2'b11;

    // addu and subu are kept apart so the ALU op survives IR changes
    typedef enum logic [3:0] {
        C_NOP,
        C_ADDU,
        C_SUBU,
        C_ORI,
        C_LUI,
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_JAL,
        C_JR
    } cls_e;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle FSM and the MIPS datapath.
interface mc_ctrl_if #(
    parameter int ALUOP_W = 3
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;
    logic               pc_en;
    logic               ir_en;
    logic               reg_we;
    logic               mem_re;
    logic               mem_we;
    logic               iord;
    logic [1:0]         regdst;
    logic               alusrc;
    logic               ext_sel;
    logic [1:0]         memtoreg;
    logic [1:0]         npc_sel;
    logic [ALUOP_W-1:0] aluop;
    logic               retire;
    logic [2:0]         state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, ir_en, reg_we, mem_re, mem_we, iord,
        output regdst, alusrc, ext_sel, memtoreg, npc_sel,
        output aluop, retire, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, ir_en, reg_we, mem_re, mem_we, iord,
        input  regdst, alusrc, ext_sel, memtoreg, npc_sel,
        input  aluop, retire, state
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct to instruction-class decode.
module mc_decode
    import mips_defs::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output cls_e       cls_o
);

    always_comb begin
        cls_o = C_NOP;
        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADDU: cls_o = C_ADDU;
                    FN_SUBU: cls_o = C_SUBU;
                    FN_JR:   cls_o = C_JR;
                    default: cls_o = C_NOP;
                endcase
            end
            OP_ORI:  cls_o = C_ORI;
            OP_LUI:  cls_o = C_LUI;
            OP_LW:   cls_o = C_LW;
            OP_SW:   cls_o = C_SW;
            OP_BEQ:  cls_o = C_BEQ;
            OP_J:    cls_o = C_J;
            OP_JAL:  cls_o = C_JAL;
            default: cls_o = C_NOP;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch, decode, execute,
// memory and write-back through the shared datapath.
module mc_ctrl
    import mips_defs::*;
#(
    parameter int ALUOP_W = 3
) (
    input  logic     clk,
    input  logic     reset,
    mc_ctrl_if.master bus
);

    state_e state_q, state_d;
    cls_e   cls_q, cls_d;
    cls_e   dec_cls;

    logic               pc_en_d, ir_en_d, reg_we_d;
    logic               mem_re_d, mem_we_d, iord_d;
    logic [1:0]         regdst_d, memtoreg_d, npc_sel_d;
    logic               alusrc_d, ext_sel_d, retire_d;
    logic [ALUOP_W-1:0] aluop_d;

    mc_decode u_decode (
        .opcode_i (bus.opcode),
        .funct_i  (bus.funct),
        .cls_o    (dec_cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cls_q   <= C_NOP;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        pc_en_d    = 1'b0;
        ir_en_d    = 1'b0;
        reg_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        iord_d     = 1'b0;
        regdst_d   = RD_RT;
        alusrc_d   = 1'b0;
        ext_sel_d  = 1'b0;
        memtoreg_d = M2R_ALU;
        npc_sel_d  = NPC_PC4;
        aluop_d    = ALUOP_W'(ALU_ADD);
        retire_d   = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_re_d = 1'b1;
                if (bus.mem_ready) begin
                    pc_en_d = 1'b1;
                    ir_en_d = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    C_J: begin
                        pc_en_d   = 1'b1;
                        npc_sel_d = NPC_J;
                        retire_d  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    C_JR: begin
                        pc_en_d   = 1'b1;
                        npc_sel_d = NPC_RS;
                        retire_d  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    C_JAL: state_d = S_WB;
                    C_NOP: begin
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                state_d = S_WB;
                case (cls_q)
                    C_SUBU: aluop_d = ALUOP_W'(ALU_SUB);
                    C_ORI: begin
                        alusrc_d = 1'b1;
                        aluop_d  = ALUOP_W'(ALU_OR);
                    end
                    C_LUI: begin
                        alusrc_d = 1'b1;
                        aluop_d  = ALUOP_W'(ALU_LUI);
                    end
                    C_LW, C_SW: begin
                        alusrc_d  = 1'b1;
                        ext_sel_d = 1'b1;
                        state_d   = S_MEM;
                    end
                    C_BEQ: begin
                        aluop_d   = ALUOP_W'(ALU_SUB);
                        pc_en_d   = bus.zero;
                        npc_sel_d = NPC_BR;
                        retire_d  = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord_d   = 1'b1;
                mem_re_d = (cls_q == C_LW);
                mem_we_d = (cls_q == C_SW);
                if (bus.mem_ready) begin
                    if (cls_q == C_SW) begin
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we_d = 1'b1;
                retire_d = 1'b1;
                state_d  = S_FETCH;
                case (cls_q)
                    C_ADDU, C_SUBU: regdst_d = RD_RD;
                    C_LW: memtoreg_d = M2R_MDR;
                    C_JAL: begin
                        regdst_d   = RD_R31;
                        memtoreg_d = M2R_PC4;
                        pc_en_d    = 1'b1;
                        npc_sel_d  = NPC_J;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_FETCH;
        endcase

        // reset suppresses every write/handshake, aborting the instruction
        if (reset) begin
            pc_en_d  = 1'b0;
            ir_en_d  = 1'b0;
            reg_we_d = 1'b0;
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
            retire_d = 1'b0;
        end
    end

    assign bus.pc_en    = pc_en_d;
    assign bus.ir_en    = ir_en_d;
    assign bus.reg_we   = reg_we_d;
    assign bus.mem_re   = mem_re_d;
    assign bus.mem_we   = mem_we_d;
    assign bus.iord     = iord_d;
    assign bus.regdst   = regdst_d;
    assign bus.alusrc   = alusrc_d;
    assign bus.ext_sel  = ext_sel_d;
    assign bus.memtoreg = memtoreg_d;
    assign bus.npc_sel  = npc_sel_d;
    assign bus.aluop    = aluop_d;
    assign bus.retire   = retire_d;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: per-cycle checks of every control
// output against hand-derived vectors.
module tb_mc_ctrl;
    import mips_defs::*;

    logic clk;
    logic reset;
    int   tests;
    int   failed;

    mc_ctrl_if #(.ALUOP_W(3)) bus ();

    mc_ctrl #(.ALUOP_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {bus.state, bus.pc_en, bus.ir_en, bus.reg_we,
                  bus.mem_re, bus.mem_we, bus.iord, bus.regdst,
                  bus.alusrc, bus.ext_sel, bus.memtoreg,
                  bus.npc_sel, bus.aluop, bus.retire};

    // {state,pc,ir,rw,mr,mw,iord,regdst,alusrc,ext,m2r,npc,aluop,ret}
    function automatic logic [20:0] mk(
        input logic [2:0] st,
        input logic pc, ir, rw, mr, mw, io,
        input logic [1:0] rd,
        input logic as, es,
        input logic [1:0] m2r, npc,
        input logic [2:0] aop,
        input logic ret
    );
        return {st, pc, ir, rw, mr, mw, io, rd, as, es, m2r, npc, aop, ret};
    endfunction

    function automatic logic [20:0] fetch_go();
        return mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [20:0] idle(input logic [2:0] st);
        return mk(st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic test_reset();
        logic [20:0] e [4];
        e[0] = idle(0);
        e[1] = idle(0);
        e[2] = fetch_go();
        e[3] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'd0;
        bus.funct = 6'd0;
        bus.zero = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) reset = 1'b0;
            @(negedge clk);
            tests++;
            if (obs !== e[i]) begin
                failed++;
                $display("FAIL reset c%0d got %h exp %h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        logic [20:0] e [4];
        for (int k = 0; k < 4; k++) begin
            e[0] = fetch_go();
            e[1] = idle(1);
            case (k)
                0: begin
                    bus.opcode = OP_RTYPE; bus.funct = FN_ADDU;
                    e[2] = idle(2);
                    e[3] = mk(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
                end
                1: begin
                    bus.opcode = OP_RTYPE; bus.funct = FN_SUBU;
                    e[2] = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                    e[3] = mk(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
                end
                2: begin
                    bus.opcode = OP_ORI; bus.funct = 6'h25;
                    e[2] = mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0);
                    e[3] = mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                end
                default: begin
                    bus.opcode = OP_LUI; bus.funct = 6'h00;
                    e[2] = mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0);
                    e[3] = mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
                end
            endcase
            bus.mem_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                tests++;
                if (obs !== e[i]) begin
                    failed++;
                    $display("FAIL alu k%0d c%0d got %h exp %h",
                             k, i, obs, e[i]);
                end
                @(posedge clk); #1;
                // IR contents after DECODE must not matter
                if (i == 1) begin
                    bus.opcode = OP_SW;
                    bus.funct = FN_JR;
                end
            end
        end
    endtask

    task automatic test_lw_stall();
        logic [20:0] e [8];
        logic        rdy [8];
        e[0] = fetch_go();
        e[1] = idle(1);
        e[2] = mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 3; i < 7; i++)
            e[i] = mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        e[7] = mk(4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        rdy = '{1, 1, 1, 0, 0, 0, 1, 1};
        bus.opcode = OP_LW;
        bus.funct = 6'h00;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = rdy[i];
            @(negedge clk);
            tests++;
            if (obs !== e[i]) begin
                failed++;
                $display("FAIL lw c%0d got %h exp %h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        logic [20:0] e [3];
        for (int z = 1; z >= 0; z--) begin
            e[0] = fetch_go();
            e[1] = idle(1);
            e[2] = mk(2, z[0], 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
            bus.opcode = OP_BEQ;
            bus.funct = 6'h00;
            bus.zero = z[0];
            bus.mem_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                tests++;
                if (obs !== e[i]) begin
                    failed++;
                    $display("FAIL beq z%0d c%0d got %h exp %h",
                             z, i, obs, e[i]);
                end
                @(posedge clk); #1;
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [20:0] e [3];
        int          n;
        for (int k = 0; k < 3; k++) begin
            e[0] = fetch_go();
            case (k)
                0: begin
                    bus.opcode = OP_JAL; bus.funct = 6'h00; n = 3;
                    e[1] = idle(1);
                    e[2] = mk(4, 1, 0, 1, 0, 0, 0, 2, 0, 0, 2, 2, 0, 1);
                end
                1: begin
                    bus.opcode = OP_RTYPE; bus.funct = FN_JR; n = 2;
                    e[1] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1);
                    e[2] = '0;
                end
                default: begin
                    bus.opcode = OP_J; bus.funct = 6'h00; n = 2;
                    e[1] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
                    e[2] = '0;
                end
            endcase
            bus.mem_ready = 1'b1;
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                tests++;
                if (obs !== e[i]) begin
                    failed++;
                    $display("FAIL jump k%0d c%0d got %h exp %h",
                             k, i, obs, e[i]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_sw();
        logic [20:0] e [6];
        logic        rdy [6];
        e[0] = fetch_go();
        e[1] = idle(1);
        e[2] = mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        e[3] = mk(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        e[4] = mk(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        e[5] = fetch_go();
        rdy = '{1, 1, 1, 0, 1, 1};
        bus.opcode = OP_SW;
        bus.funct = 6'h00;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = rdy[i];
            @(negedge clk);
            tests++;
            if (obs !== e[i]) begin
                failed++;
                $display("FAIL sw c%0d got %h exp %h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
        // the trailing fetch went to DECODE; finish it as a NOP
        bus.opcode = 6'h3f;
        @(negedge clk);
        tests++;
        if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
            failed++;
            $display("FAIL sw_tail got %h", obs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sw_reset_abort();
        logic [20:0] e [7];
        logic        rdy [7];
        logic        rst [7];
        e[0] = fetch_go();
        e[1] = idle(1);
        e[2] = mk(2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        e[3] = mk(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        e[4] = mk(3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        e[5] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e[6] = fetch_go();
        rdy = '{1, 1, 1, 0, 0, 0, 1};
        rst = '{0, 0, 0, 0, 1, 0, 0};
        bus.opcode = OP_SW;
        bus.funct = 6'h00;
        for (int i = 0; i < 7; i++) begin
            bus.mem_ready = rdy[i];
            reset = rst[i];
            @(negedge clk);
            tests++;
            if (obs !== e[i]) begin
                failed++;
                $display("FAIL swrst c%0d got %h exp %h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
        bus.opcode = 6'h3f;
        @(negedge clk);
        tests++;
        if (obs !== mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)) begin
            failed++;
            $display("FAIL swrst_tail got %h", obs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_undef();
        logic [20:0] e [3];
        e[0] = fetch_go();
        e[1] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        e[2] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.opcode = 6'b111111;
        bus.funct = 6'b111111;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = (i != 2);
            @(negedge clk);
            tests++;
            if (obs !== e[i]) begin
                failed++;
                $display("FAIL undef c%0d got %h exp %h", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        test_reset();
        test_alu();
        test_lw_stall();
        test_beq();
        test_jumps();
        test_sw();
        test_sw_reset_abort();
        test_undef();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
